// File: rtl/seg_scan_driver.sv
// Multiplexed 8-digit scan driver: one-hot digit select with blanking dead time and a double-buffered frame.
// Optional SEG_BLINK_EN adds a blink_mask port and a free-running blink phase.
module seg_scan_driver #(
    parameter int unsigned NUM_DIG   = 8,
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 1000,
    parameter int unsigned BLINK_DIV = 50000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6*NUM_DIG-1:0] frame_in,
    input  logic                 frame_load,
    input  logic [NUM_DIG-1:0]   enable_mask,
`ifdef SEG_BLINK_EN
    input  logic [NUM_DIG-1:0]   blink_mask,
`endif
    output logic                 frame_pending,
    output logic                 load_ack,
    output logic [5:0]           seg_code,
    output logic [NUM_DIG-1:0]   dig_sel
);

    localparam int unsigned CNT_MAX   = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int unsigned CNT_RANGE = (CNT_MAX > 2) ? CNT_MAX : 2;
    localparam int unsigned CW        = $clog2(CNT_RANGE);
    localparam int unsigned IW        = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam bit          HAS_BLANK = (BLANK_CYC != 0);

    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(HAS_BLANK ? BLANK_CYC - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIG - 1);
    localparam logic [5:0]    SYM_BLANK  = 6'h3F;

    if (NUM_DIG < 1 || NUM_DIG > 8 || SCAN_DIV < 1 || BLINK_DIV < 1) begin : g_param_check
        $error("seg_scan_driver: illegal parameter value");
    end

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_e;

    localparam state_e RST_STATE = HAS_BLANK ? ST_BLANK : ST_SHOW;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 wrap;
    logic [5:0]           active_q [NUM_DIG];
    logic [5:0]           active_d [NUM_DIG];
    logic [5:0]           pend_q   [NUM_DIG];
    logic [5:0]           pend_d   [NUM_DIG];
    logic                 pending_q, pending_d;
    logic                 load_ack_q, load_ack_d;
    logic [NUM_DIG-1:0]   dig_sel_q, dig_sel_d;
    logic [5:0]           seg_code_q, seg_code_d;
    logic                 commit;
    logic                 lit;
    logic                 blink_off;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RST_STATE;
            cnt_q      <= '0;
            idx_q      <= '0;
            active_q   <= '{default: SYM_BLANK};
            pend_q     <= '{default: SYM_BLANK};
            pending_q  <= 1'b0;
            load_ack_q <= 1'b0;
            dig_sel_q  <= '0;
            seg_code_q <= SYM_BLANK;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            active_q   <= active_d;
            pend_q     <= pend_d;
            pending_q  <= pending_d;
            load_ack_q <= load_ack_d;
            dig_sel_q  <= dig_sel_d;
            seg_code_q <= seg_code_d;
        end
    end

    // Single counter restarts on every state change; wrap marks entry into digit 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        wrap    = 1'b0;
        unique case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    cnt_d   = '0;
                    state_d = HAS_BLANK ? ST_BLANK : ST_SHOW;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                        wrap  = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = RST_STATE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef SEG_BLINK_EN
    localparam int unsigned BLINK_RANGE = (BLINK_DIV > 2) ? BLINK_DIV : 2;
    localparam int unsigned BW          = $clog2(BLINK_RANGE);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic          blink_hold_q, blink_hold_d;
    logic          slot_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            blink_hold_q  <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            blink_hold_q  <= blink_hold_d;
        end
    end

    // Phase is latched when a SHOW slot begins so a digit never changes mid-slot.
    always_comb begin
        blink_cnt_d   = blink_cnt_q + BW'(1);
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
        slot_start   = (state_d == ST_SHOW) && (cnt_d == '0);
        blink_hold_d = slot_start ? blink_phase_d : blink_hold_q;
        blink_off    = blink_hold_d & blink_mask[idx_d];
    end
`else
    assign blink_off = 1'b0;
`endif

    // Outputs are computed from next-state values so the registered outputs line up with the state.
    always_comb begin
        commit     = wrap & pending_q;
        active_d   = active_q;
        pend_d     = pend_q;
        if (commit) begin
            active_d = pend_q;
        end
        if (frame_load) begin
            for (int unsigned k = 0; k < NUM_DIG; k++) begin
                pend_d[k] = frame_in[6*k +: 6];
            end
        end
        pending_d  = frame_load | (pending_q & ~commit);
        load_ack_d = commit;
        lit        = (state_d == ST_SHOW) && enable_mask[idx_d] && !blink_off;
        dig_sel_d  = lit ? (NUM_DIG'(1) << idx_d) : '0;
        seg_code_d = lit ? active_d[idx_d] : SYM_BLANK;
    end

    assign frame_pending = pending_q;
    assign load_ack      = load_ack_q;
    assign seg_code      = seg_code_q;
    assign dig_sel       = dig_sel_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboarded bench for seg_scan_driver: a frame-position reference model queues expected outputs per cycle.
module tb_seg_scan_driver;

    localparam int ND   = 8;
    localparam int SD   = 4;
    localparam int BC   = 2;
    localparam int BD   = 40;
    localparam int SLOT = SD + BC;
    localparam int FP   = ND * SLOT;

    logic          clk = 1'b0;
    logic          rst;
    logic [47:0]   frame_in;
    logic          frame_load;
    logic [7:0]    enable_mask;
    logic          frame_pending;
    logic          load_ack;
    logic [5:0]    seg_code;
    logic [7:0]    dig_sel;

    seg_scan_driver #(
        .NUM_DIG   (ND),
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC),
        .BLINK_DIV (BD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_in      (frame_in),
        .frame_load    (frame_load),
        .enable_mask   (enable_mask),
`ifdef SEG_BLINK_EN
        .blink_mask    (8'h00),
`endif
        .frame_pending (frame_pending),
        .load_ack      (load_ack),
        .seg_code      (seg_code),
        .dig_sel       (dig_sel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] dig;
        logic [5:0] seg;
        logic       pend;
        logic       ack;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    bit         done     = 1'b0;

    // Reference model: position within the frame, active and pending frames as arrays.
    int         pos = 0;
    logic [5:0] act  [ND];
    logic [5:0] pbuf [ND];
    bit         pnd = 1'b0;
    logic [7:0] en_cur = 8'hFF;

    task automatic model_step(input bit r, input bit ld, input logic [47:0] fr, input logic [7:0] en);
        exp_t e;
        int   dg;
        bit   show;
        if (r) begin
            pos = 0;
            for (int k = 0; k < ND; k++) begin
                act[k]  = 6'h3F;
                pbuf[k] = 6'h3F;
            end
            pnd   = 1'b0;
            e.dig = 8'h00;
            e.seg = 6'h3F;
            e.pend = 1'b0;
            e.ack  = 1'b0;
        end else begin
            pos   = (pos + 1) % FP;
            e.ack = 1'b0;
            if (pos == 0 && pnd) begin
                for (int k = 0; k < ND; k++) act[k] = pbuf[k];
                pnd   = 1'b0;
                e.ack = 1'b1;
            end
            if (ld) begin
                for (int k = 0; k < ND; k++) pbuf[k] = fr[6*k +: 6];
                pnd = 1'b1;
            end
            e.pend = pnd;
            dg   = pos / SLOT;
            show = (pos % SLOT) >= BC;
            if (show && en[dg]) begin
                e.dig = 8'(1 << dg);
                e.seg = act[dg];
            end else begin
                e.dig = 8'h00;
                e.seg = 6'h3F;
            end
        end
        exp_q.push_back(e);
    endtask

    function automatic logic [47:0] rand_frame();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[47:0];
    endfunction

    function automatic logic [47:0] fill_frame(input logic [5:0] base, input bit ramp);
        logic [47:0] f;
        for (int k = 0; k < ND; k++) f[6*k +: 6] = ramp ? 6'(base + 6'(k)) : base;
        return f;
    endfunction

    task automatic drive(input bit r, input bit ld, input logic [47:0] fr, input logic [7:0] en);
        @(negedge clk);
        rst         = r;
        frame_load  = ld;
        frame_in    = fr;
        enable_mask = en;
        model_step(r, ld, fr, en);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, rand_frame(), en_cur);
    endtask

    // Advance until the next clock edge will move the scan to frame position 'target'.
    task automatic run_to(input int target);
        for (int i = 0; i < FP && ((pos + 1) % FP) != target; i++) begin
            drive(1'b0, 1'b0, rand_frame(), en_cur);
        end
    endtask

    task automatic load_at(input int target, input logic [47:0] fr);
        run_to(target);
        drive(1'b0, 1'b1, fr, en_cur);
    endtask

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL queue_underflow: got 0 entries expected 1 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("dig_sel", dig_sel, e.dig);
                    check("seg_code", 8'(seg_code), 8'(e.seg));
                    check("frame_pending", 8'(frame_pending), 8'(e.pend));
                    check("load_ack", 8'(load_ack), 8'(e.ack));
                end
            end
        end
    end

    initial begin : stimulus
        rst         = 1'b1;
        frame_load  = 1'b0;
        frame_in    = '0;
        enable_mask = 8'hFF;
        model_step(1'b1, 1'b0, '0, 8'hFF);
        drive(1'b1, 1'b0, '0, 8'hFF);
        drive(1'b1, 1'b1, rand_frame(), 8'hFF);

        // Idle frame: blanks everywhere, scan pattern only.
        idle(FP + 2);
        // Ramp 0..7 loaded mid-frame, visible from the next frame.
        load_at(10, fill_frame(6'h00, 1'b1));
        idle(FP + 10);
        // Two loads before the boundary: last one wins, one ack.
        load_at(5, fill_frame(6'h01, 1'b0));
        load_at(20, fill_frame(6'h02, 1'b0));
        idle(FP + 4);
        // Load on the commit edge: older frame committed, new one waits a frame.
        load_at(30, fill_frame(6'h10, 1'b1));
        load_at(0, fill_frame(6'h20, 1'b1));
        idle(2 * FP + 4);
        // Digit 0 masked off.
        en_cur = 8'hFE;
        idle(FP + 3);
        en_cur = 8'hFF;
        // Reset during digit 5 SHOW with a frame pending.
        load_at(12, fill_frame(6'h30, 1'b1));
        run_to(5 * SLOT + BC + 1);
        drive(1'b1, 1'b0, rand_frame(), en_cur);
        idle(FP + 5);

        // Randomized traffic.
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(9) == 0) en_cur = ($urandom_range(1) == 1) ? 8'hFF : 8'($urandom());
            drive(($urandom_range(199) == 0), ($urandom_range(11) == 0), rand_frame(), en_cur);
        end
        idle(4);

        @(posedge clk);
        #2;
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
